// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key expansion, valid/ready I/O.
// Optional `AES_ABORT_EN adds an abort input that drops the block in flight.
module aes_enc_round_ctrl #(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_text,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_text,
   output logic         busy
`ifdef AES_ABORT_EN
   ,
   input  logic         abort
`endif
);

   typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} st_e;

   // Byte i of a 128-bit block sits at bits [127-8i -: 8]; bytes are column-major.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r, x, e;
      r = 8'h01;
      x = a;
      e = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gf_mul(r, x);
         x = gf_mul(x, x);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w3, t, n0, n1, n2, n3;
      w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   st_e          st_q, st_d;
   logic [127:0] state_q, state_d, rk_q, rk_d, out_q, out_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] rk_next, sr_out, mc_out;
   logic         abort_req, abort_hit;

`ifdef AES_ABORT_EN
   assign abort_req = abort;
   assign abort_hit = abort && (st_q != StIdle);
`else
   assign abort_req = 1'b0;
   assign abort_hit = 1'b0;
`endif

   assign rk_next = key_exp(rk_q, rcon(round_q));
   assign sr_out  = shift_rows(sub_bytes(state_q));
   assign mc_out  = mix_columns(sr_out);

   always_comb begin
      st_d    = st_q;
      state_d = state_q;
      rk_d    = rk_q;
      out_d   = out_q;
      round_d = round_q;
      unique case (st_q)
         StIdle: begin
            if (in_valid && !abort_req) begin
               state_d = in_text ^ in_key;
               rk_d    = in_key;
               round_d = 4'd1;
               st_d    = (NUM_ROUNDS == 1) ? StFinal : StRound;
            end
         end
         StRound: begin
            state_d = mc_out ^ rk_next;
            rk_d    = rk_next;
            round_d = round_q + 4'd1;
            if (round_q == 4'(NUM_ROUNDS - 1)) st_d = StFinal;
         end
         StFinal: begin
            state_d = sr_out ^ rk_next;
            out_d   = sr_out ^ rk_next;
            rk_d    = rk_next;
            st_d    = StDone;
         end
         StDone: begin
            if (out_ready) begin
               st_d    = StIdle;
               round_d = 4'd0;
            end
         end
         default: st_d = StIdle;
      endcase
      // Abort wins over the output handshake; out_text is left untouched.
      if (abort_hit) begin
         st_d    = StIdle;
         round_d = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= StIdle;
         state_q <= '0;
         rk_q    <= '0;
         out_q   <= '0;
         round_q <= '0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         rk_q    <= rk_d;
         out_q   <= out_d;
         round_q <= round_d;
      end
   end

   assign in_ready  = (st_q == StIdle);
   assign out_valid = (st_q == StDone);
   assign busy      = (st_q == StRound) || (st_q == StFinal);
   assign out_text  = out_q;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Directed bench for aes_enc_round_ctrl using the FIPS-197 App.B / App.C.1 vectors.
module tb_aes_enc_round_ctrl;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic [127:0] in_text, in_key;
   logic         in_ready, out_valid, busy;
   logic [127:0] out_text;
`ifdef AES_ABORT_EN
   logic         abort;
`endif

   int total = 0;
   int bad   = 0;

   aes_enc_round_ctrl #(.NUM_ROUNDS(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_text   (in_text),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_text  (out_text),
      .busy      (busy)
`ifdef AES_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Offer a block, wait (bounded) for acceptance, then scramble the inputs.
   task automatic send(input logic [127:0] key, input logic [127:0] pt);
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_text  = pt;
      in_key   = key;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 128'(n), 128'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_text  = ~pt;
      in_key   = ~key;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("drain_valid_low", 128'(out_valid), 128'd0);
   endtask

   initial begin
      int n, k1, k2, ki;
      logic [127:0] ct1, ct2;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_text   = '0;
      in_key    = '0;
`ifdef AES_ABORT_EN
      abort     = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_out_text", out_text, 128'd0);

      // App.B with exact latency
      send(KEY_B, PT_B);
      chk("b_busy", 128'(busy), 128'd1);
      chk("b_in_ready_low", 128'(in_ready), 128'd0);
      wait_out(n);
      chk("b_latency", 128'(n), 128'd10);
      chk("b_ct", out_text, CT_B);
      drain();

      // App.C.1 with backpressure, second block waiting
      send(KEY_C, PT_C);
      wait_out(n);
      chk("c_latency", 128'(n), 128'd10);
      chk("c_ct", out_text, CT_C);
      in_valid = 1'b1;
      in_text  = PT_B;
      in_key   = KEY_B;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("bp_stable", out_text, CT_C);
         chk("bp_in_ready", 128'(in_ready), 128'd0);
         chk("bp_out_valid", 128'(out_valid), 128'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_after_hs_valid", 128'(out_valid), 128'd0);
      chk("bp_after_hs_ready", 128'(in_ready), 128'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_text  = '0;
      in_key   = '0;
      chk("bp2_busy", 128'(busy), 128'd1);
      wait_out(n);
      chk("bp2_latency", 128'(n), 128'd10);
      chk("bp2_ct", out_text, CT_B);
      drain();

      // Back-to-back with out_ready held high
      @(negedge clk);
      in_valid  = 1'b1;
      in_text   = PT_B;
      in_key    = KEY_B;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_text = PT_C;
      in_key  = KEY_C;
      k1 = 0; k2 = 0; ki = 0; ct1 = '0; ct2 = '0;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (ki != 0 && k == ki + 1) in_valid = 1'b0;
         if (out_valid && k1 == 0) begin
            k1 = k;
            ct1 = out_text;
         end else if (out_valid && k2 == 0 && k > k1 + 1) begin
            k2 = k;
            ct2 = out_text;
         end
         if (in_ready && ki == 0) ki = k;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("b2b_first_at", 128'(k1), 128'd10);
      chk("b2b_first_ct", ct1, CT_B);
      chk("b2b_accept_spacing", 128'(ki + 1), 128'd12);
      chk("b2b_second_at", 128'(k2), 128'd22);
      chk("b2b_second_ct", ct2, CT_C);

      // Mid-run reset, then a fresh App.C.1 block
      send(KEY_B, PT_B);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_in_ready", 128'(in_ready), 128'd1);
      chk("mrst_out_valid", 128'(out_valid), 128'd0);
      chk("mrst_busy", 128'(busy), 128'd0);
      chk("mrst_out_text", out_text, 128'd0);
      send(KEY_C, PT_C);
      wait_out(n);
      chk("mrst_latency", 128'(n), 128'd10);
      chk("mrst_ct", out_text, CT_C);
      drain();

`ifdef AES_ABORT_EN
      // Abort mid-run: no output pulse, out_text retained, next block correct
      send(KEY_C, PT_C);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_in_ready", 128'(in_ready), 128'd1);
      chk("abort_busy", 128'(busy), 128'd0);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) n++;
         @(negedge clk);
      end
      chk("abort_no_valid", 128'(n), 128'd0);
      chk("abort_out_text_kept", out_text, CT_C);
      send(KEY_B, PT_B);
      wait_out(n);
      chk("abort_next_latency", 128'(n), 128'd10);
      chk("abort_next_ct", out_text, CT_B);
      drain();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
